// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
//   REG_AW       : register-index width (32 architectural registers, x0 = 0)
//   FWD_*        : operand-mux select encodings (11 is reserved, never driven)
//   stage_tag_t  : register tags carried by an in-flight instruction
//   TAG_BUBBLE   : all-zero tag, used for bubbles, flushes and reset
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;   // ID/EX register-file value
    localparam logic [1:0] FWD_MEM = 2'b10;   // EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b01;   // MEM/WB write-back data

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel_unit
// Priority compare of one EX source-register tag against the MEM and WB
// destination tags; produces the 2-bit operand-mux select.
//   src_rs       in  : EX-stage source register index
//   mem_rd       in  : MEM-stage destination register index
//   mem_regwrite in  : MEM-stage instruction writes the register file
//   wb_rd        in  : WB-stage destination register index
//   wb_regwrite  in  : WB-stage instruction writes the register file
//   sel          out : FWD_MEM / FWD_WB / FWD_RF
// ---------------------------------------------------------------------------
module fwd_sel_unit
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] src_rs,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_regwrite,
    output logic [1:0]    sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it never produces a value to forward.
    assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == src_rs);
    assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src_rs);

    // MEM holds the newer producer, so it wins when both stages match.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the EX stage of a 5-stage
// pipeline. Tracks register tags of in-flight instructions in EX/MEM/WB tag
// registers, drives the two operand-mux selects, and issues a one-cycle
// load-use stall (hold PC and IF/ID, bubble into EX).
//   clk_i          in  : clock, all state on rising edge
//   rst_i          in  : synchronous reset, active-high
//   id_valid_i     in  : ID instruction valid
//   id_rs1_i/rs2_i in  : ID source registers
//   id_rd_i        in  : ID destination register
//   id_regwrite_i  in  : ID instruction writes register file
//   id_memread_i   in  : ID instruction is a load
//   flush_i        in  : squash ID instruction, bubble into EX
//   fwd_a_o/b_o    out : operand-A / operand-B mux selects
//   stall_o        out : load-use stall
//   stall_cnt_o    out : saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    stage_tag_t        ex_reg, ex_next;
    logic [REG_AW-1:0] mem_rd_reg, wb_rd_reg;
    logic              mem_regwrite_reg, wb_regwrite_reg;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic              stall;

    logic [REG_AW-1:0] ex_src   [2];
    logic [1:0]        fwd_sel  [2];

    // A squashed or invalid instruction never stalls; rd == 0 loads have no
    // real consumer dependency.
    assign stall = id_valid_i && !flush_i && ex_reg.memread && (ex_reg.rd != '0)
                && ((ex_reg.rd == id_rs1_i) || (ex_reg.rd == id_rs2_i));

    always_comb begin
        ex_next = TAG_BUBBLE;
        if (id_valid_i && !flush_i && !stall) begin
            ex_next.rs1      = id_rs1_i;
            ex_next.rs2      = id_rs2_i;
            ex_next.rd       = id_rd_i;
            ex_next.regwrite = id_regwrite_i;
            ex_next.memread  = id_memread_i;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_reg           <= TAG_BUBBLE;
            mem_rd_reg       <= '0;
            mem_regwrite_reg <= 1'b0;
            wb_rd_reg        <= '0;
            wb_regwrite_reg  <= 1'b0;
            stall_cnt_reg    <= '0;
        end else begin
            ex_reg           <= ex_next;
            mem_rd_reg       <= ex_reg.rd;
            mem_regwrite_reg <= ex_reg.regwrite;
            wb_rd_reg        <= mem_rd_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            stall_cnt_reg    <= stall_cnt_next;
        end
    end

    // Selects depend only on registered tags: no ID-input-to-select path.
    assign ex_src[0] = ex_reg.rs1;
    assign ex_src[1] = ex_reg.rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel_unit #(
                .AW (REG_AW)
            ) u_sel (
                .src_rs       (ex_src[gi]),
                .mem_rd       (mem_rd_reg),
                .mem_regwrite (mem_regwrite_reg),
                .wb_rd        (wb_rd_reg),
                .wb_regwrite  (wb_regwrite_reg),
                .sel          (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_a_o     = fwd_sel[0];
    assign fwd_b_o     = fwd_sel[1];
    assign stall_o     = stall;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the two 32-bit 4:1 operand multiplexers in the EX stage of the 5-stage pipelined CPU.
- Tracks destination/source register tags of in-flight instructions through internal EX/MEM/WB tag registers.
- Drives the two 2-bit forwarding selects and detects load-use hazards, issuing a one-cycle stall and bubble.
- Keeps a saturating stall counter for performance reporting.

Parameters:
REG_AW, 5, register-index width (32 architectural registers, x0 hard-wired zero).
CNT_W, 32, width of stall counter.

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_i  input  1  synchronous reset, active-high.
id_valid_i  input  1  ID-stage instruction is valid (low = bubble/flushed).
id_rs1_i  input  REG_AW  ID source register 1.
id_rs2_i  input  REG_AW  ID source register 2.
id_rd_i  input  REG_AW  ID destination register.
id_regwrite_i  input  1  ID instruction writes register file.
id_memread_i  input  1  ID instruction is a load.
flush_i  input  1  squash current ID instruction (branch taken); forces bubble into EX.
fwd_a_o  output  2  select for operand-A mux.
fwd_b_o  output  2  select for operand-B mux.
stall_o  output  1  load-use stall: hold PC and IF/ID, bubble into EX.
stall_cnt_o  output  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Select encoding (shared): 00 = ID/EX register-file value; 10 = EX/MEM ALU result; 01 = MEM/WB write-back data; 11 reserved, never driven.
- Tag registers: EX {rs1, rs2, rd, regwrite, memread}, MEM {rd, regwrite}, WB {rd, regwrite}.
- Reset (rst_i high at an edge): all tag fields cleared to 0, stall_cnt_o = 0; consequently fwd_a_o = fwd_b_o = 00, stall_o = 0 from the following cycle. Reset takes priority over all other inputs and may hit mid-stall; no stall carries over.
- Each edge (not reset): WB <= MEM; MEM <= {EX.rd, EX.regwrite}; EX <= ID tags if id_valid_i && !flush_i && !stall_o, else EX <= bubble (all fields 0).
- stall_o (combinational): id_valid_i && !flush_i && EX.memread && EX.rd != 0 && (EX.rd == id_rs1_i || EX.rd == id_rs2_i). Asserts exactly one cycle per load-use pair: the bubble clears EX.memread, and the load moves to MEM where it is forwarded via WB path next.
- Forwarding (combinational from registered tags only, no input-to-output path):
  - fwd_a_o = 10 if MEM.regwrite && MEM.rd != 0 && MEM.rd == EX.rs1; else 01 if WB.regwrite && WB.rd != 0 && WB.rd == EX.rs1; else 00. fwd_b_o is the same using EX.rs2.
  - MEM beats WB when both match (newest value).
  - rd == 0 never forwards.
- Latency: ID tags sampled at edge n drive selects during cycle n+1 (instruction in EX).
- flush_i and stall_o: flush masks the stall (a squashed instruction does not stall); the counter does not increment.
- stall_cnt_o increments by 1 on every edge where stall_o is high; holds at all-ones.
- Write-back-to-decode same-cycle hazard is resolved by register-file write-first; not handled here.

Decomposition:
- Shared package: select constants FWD_RF = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01; REG_AW; stage tag struct/typedef {rs1, rs2, rd, regwrite, memread}.
- One natural sub-module: fwd_sel_unit (combinational priority compare of one source tag against MEM/WB tags), instantiated twice for A and B.

Test Plan:
- Reset: assert rst_i 2 cycles with random ID inputs -> fwd_a_o = fwd_b_o = 00, stall_o = 0, stall_cnt_o = 0 after the reset edge.
- EX/MEM forward: add x5 then sub x6 ← x5,x7 back-to-back -> in sub's EX cycle fwd_a_o = 10, fwd_b_o = 00.
- MEM/WB and priority: add x5; add x5; sub x8 ← x5,x5 -> sub in EX gets fwd_a_o = fwd_b_o = 10. With one unrelated instruction in between instead -> 01.
- Load-use: lw x4 then add x9 ← x4,x4 -> stall_o = 1 for exactly 1 cycle, EX bubble, then add in EX with fwd_a_o = fwd_b_o = 01; stall_cnt_o = 1.
- x0 and flush: lw x0 then use x0 -> no stall, selects 00. lw x4 then use x4 with flush_i = 1 -> stall_o = 0, counter unchanged.
- Reset mid-stall: rst_i high during stall_o = 1 -> next cycle stall_o = 0, counter 0, all selects 00.
